// File: rtl/xz_debounce_pkg.sv
// Shared types and defaults for the x/z input debouncer.
package xz_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } chan_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W         = 8;
    localparam int unsigned DEF_GLITCH_W      = 8;

endpackage

// File: rtl/xz_deb_chan.sv
// One debounce channel: 2-flop synchroniser, qualification FSM, registered
// clean level, and a combinational strobe on an aborted transition.
module xz_deb_chan
    import xz_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic en,
    output logic out,
    output logic out_nxt_c,
    output logic glitch_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              sync1;
    logic              sync2;
    chan_state_e       state;
    chan_state_e       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Synchroniser runs independently of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOW;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt_c;
        end
    end

    // Disabling abandons an in-flight qualification without counting it as a glitch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        glitch_c  = 1'b0;
        case (state)
            ST_LOW: begin
                if (en && sync2) begin
                    state_nxt = ST_RISE;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_RISE: begin
                if (!en) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (!sync2) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                    glitch_c  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (en && !sync2) begin
                    state_nxt = ST_FALL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_FALL: begin
                if (!en) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (sync2) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                    glitch_c  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
        out_nxt_c = (state_nxt == ST_HIGH) || (state_nxt == ST_FALL);
    end

endmodule

// File: rtl/xz_debounce.sv
// Debounced x/z pair for the downstream state tracker, with change pulse
// and a saturating glitch counter covering both channels.
module xz_debounce
    import xz_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned GLITCH_W      = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                x_raw,
    input  logic                z_raw,
    input  logic                en,
    input  logic                glitch_clr,
    output logic                x,
    output logic                z,
    output logic                xz_chg,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    logic              x_nxt_c;
    logic              z_nxt_c;
    logic              x_glitch_c;
    logic              z_glitch_c;
    logic [1:0]        glitch_add_c;
    logic [GLITCH_W:0] glitch_sum_c;

    xz_deb_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_x (
        .clk       (clk),
        .rst       (rst),
        .raw       (x_raw),
        .en        (en),
        .out       (x),
        .out_nxt_c (x_nxt_c),
        .glitch_c  (x_glitch_c)
    );

    xz_deb_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_z (
        .clk       (clk),
        .rst       (rst),
        .raw       (z_raw),
        .en        (en),
        .out       (z),
        .out_nxt_c (z_nxt_c),
        .glitch_c  (z_glitch_c)
    );

    // At most +2 per edge, so the carry bit alone signals saturation.
    always_comb begin
        glitch_add_c = 2'(x_glitch_c) + 2'(z_glitch_c);
        glitch_sum_c = (GLITCH_W+1)'(glitch_cnt) + (GLITCH_W+1)'(glitch_add_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xz_chg     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            xz_chg <= (x_nxt_c != x) || (z_nxt_c != z);
            if (glitch_clr) begin
                glitch_cnt <= '0;
            end else if (glitch_sum_c[GLITCH_W]) begin
                glitch_cnt <= '1;
            end else begin
                glitch_cnt <= glitch_sum_c[GLITCH_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_xz_debounce.sv
// Scoreboard bench for xz_debounce: a run-length reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_xz_debounce;

    localparam int unsigned SC   = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned GW   = 8;
    localparam int          GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x_raw = 1'b0;
    logic          z_raw = 1'b0;
    logic          en = 1'b1;
    logic          glitch_clr = 1'b0;
    logic          x;
    logic          z;
    logic          xz_chg;
    logic [GW-1:0] glitch_cnt;

    always #5 clk = ~clk;

    xz_debounce #(
        .STABLE_CYCLES (SC),
        .CNT_W         (CW),
        .GLITCH_W      (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_raw      (x_raw),
        .z_raw      (z_raw),
        .en         (en),
        .glitch_clr (glitch_clr),
        .x          (x),
        .z          (z),
        .xz_chg     (xz_chg),
        .glitch_cnt (glitch_cnt)
    );

    typedef struct packed {
        logic          x;
        logic          z;
        logic          chg;
        logic [GW-1:0] gc;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   chg_seen = 0;

    // Reference: two-sample delay line, then per channel a count of
    // consecutive samples disagreeing with the accepted level.
    bit m_s1[2];
    bit m_s2[2];
    bit m_out[2];
    int m_run[2];
    int m_gcnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit raw[2];
        bit prev[2];
        int g;
        obs_t e;
        raw[0] = x_raw;
        raw[1] = z_raw;
        g = 0;
        prev = m_out;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_run[c] = 0;
            end
            m_gcnt = 0;
            prev = m_out;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!en) begin
                    m_run[c] = 0;
                end else if (m_s2[c] != m_out[c]) begin
                    m_run[c]++;
                    if (m_run[c] == int'(SC)) begin
                        m_out[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else if (m_run[c] > 0) begin
                    g++;
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
            if (glitch_clr) m_gcnt = 0;
            else m_gcnt = (m_gcnt + g > GMAX) ? GMAX : m_gcnt + g;
        end
        e.x   = m_out[0];
        e.z   = m_out[1];
        e.chg = (m_out[0] != prev[0]) || (m_out[1] != prev[1]);
        e.gc  = GW'(m_gcnt);
        sb_q.push_back(e);
    endtask

    // Inputs change just after the falling edge; the model runs at the rising edge.
    task automatic step(input bit xr, input bit zr, input bit e, input bit clr, input bit r);
        @(negedge clk);
        #1;
        x_raw = xr; z_raw = zr; en = e; glitch_clr = clr; rst = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic steps(input int n, input bit xr, input bit zr, input bit e, input bit clr);
        for (int i = 0; i < n; i++) step(xr, zr, e, clr, 1'b0);
    endtask

    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {x, z, xz_chg, glitch_cnt};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard at %0t: got x=%b z=%b chg=%b gc=%0d expected x=%b z=%b chg=%b gc=%0d",
                         $time, a.x, a.z, a.chg, a.gc, e.x, e.z, e.chg, e.gc);
            end
            if (xz_chg === 1'b1) chg_seen++;
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        check("reset_x", int'(x), 0);
        check("reset_gc", int'(glitch_cnt), 0);

        // Single clean rise on x.
        c0 = chg_seen;
        steps(4, 1, 0, 1, 0);
        check("x_before_latency", int'(x), 0);
        steps(8, 1, 0, 1, 0);
        check("x_rise", int'(x), 1);
        check("x_rise_pulses", chg_seen - c0, 1);
        check("x_rise_gc", int'(glitch_cnt), 0);
        steps(10, 0, 0, 1, 0);
        check("x_fall", int'(x), 0);

        // Two-sample pulse from LOW is rejected.
        c0 = chg_seen;
        steps(2, 1, 0, 1, 0);
        steps(8, 0, 0, 1, 0);
        check("short_x", int'(x), 0);
        check("short_gc", int'(glitch_cnt), 1);
        check("short_pulses", chg_seen - c0, 0);

        // Simultaneous rise gives one pulse; then a double glitch adds 2.
        c0 = chg_seen;
        steps(10, 1, 1, 1, 0);
        check("both_x", int'(x), 1);
        check("both_z", int'(z), 1);
        check("both_pulses", chg_seen - c0, 1);
        steps(10, 0, 0, 1, 0);
        steps(2, 1, 1, 1, 0);
        steps(8, 0, 0, 1, 0);
        check("double_gc", int'(glitch_cnt), 3);

        // From x=1: three low samples abort, four complete the fall.
        steps(10, 1, 0, 1, 0);
        steps(3, 0, 0, 1, 0);
        steps(8, 1, 0, 1, 0);
        check("hold_high_x", int'(x), 1);
        check("hold_high_gc", int'(glitch_cnt), 4);
        steps(5, 0, 0, 1, 0);
        check("fall_before_latency", int'(x), 1);
        steps(1, 0, 0, 1, 0);
        check("fall_latency", int'(x), 0);

        // Saturation of the glitch counter and clear priority.
        steps(1, 0, 0, 1, 1);
        check("clr_gc", int'(glitch_cnt), 0);
        for (int i = 0; i < 127; i++) begin
            steps(2, 1, 1, 1, 0);
            steps(4, 0, 0, 1, 0);
        end
        check("preset_gc", int'(glitch_cnt), 254);
        steps(2, 1, 1, 1, 0);
        steps(4, 0, 0, 1, 0);
        check("sat_gc", int'(glitch_cnt), GMAX);
        steps(2, 1, 0, 1, 1);
        steps(4, 0, 0, 1, 1);
        check("clr_prio_gc", int'(glitch_cnt), 0);

        // en=0 mid-RISE drops back to LOW without a glitch.
        steps(3, 1, 0, 1, 0);
        steps(4, 1, 0, 0, 0);
        steps(2, 0, 0, 0, 0);
        steps(6, 0, 0, 1, 0);
        check("en_x", int'(x), 0);
        check("en_gc", int'(glitch_cnt), 0);

        // Asynchronous reset mid-FALL.
        steps(10, 1, 0, 1, 0);
        steps(4, 0, 0, 1, 0);
        check("pre_rst_x", int'(x), 1);
        #6;
        rst = 1'b1;
        #1;
        check("async_rst_x", int'(x), 0);
        check("async_rst_chg", int'(xz_chg), 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);

        // Randomised segments.
        for (int s = 0; s < 300; s++) begin
            bit xr;
            bit zr;
            bit e;
            bit clr;
            int len;
            xr  = 1'($urandom_range(0, 1));
            zr  = 1'($urandom_range(0, 1));
            e   = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 29) == 0);
            len = $urandom_range(1, 8);
            steps(len, xr, zr, e, clr);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
